// File: rtl/ct_spsram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ct_spsram_arb_pkg
//  Shared definitions for the ct_spsram_2048x128 arbiter slice:
//   - arb_state_e  : arbiter FSM state (INIT = zero-fill, RUN = serve requesters)
//   - SRAM_*       : macro geometry
//   - *_OFF        : inactive levels of the active-low macro strobes
// ---------------------------------------------------------------------------
package ct_spsram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 11;
    localparam int unsigned SRAM_DATA_W = 128;
    localparam int unsigned SRAM_DEPTH  = 2048;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam logic                   CEN_OFF  = 1'b1;
    localparam logic                   GWEN_OFF = 1'b1;
    localparam logic [SRAM_DATA_W-1:0] WEN_OFF  = '1;

endpackage

// File: rtl/ct_spsram_init_cnt.sv
// ---------------------------------------------------------------------------
// ct_spsram_init_cnt
//  Fill-index counter used while the array is being zero-filled.
//  Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_en       in   advance the counter by one this cycle
//   i_restart  in   force the counter back to 0 (wins over i_en)
//   o_cnt      out  current fill index
//   o_last     out  current index is the final entry of the array
// ---------------------------------------------------------------------------
module ct_spsram_init_cnt
    import ct_spsram_arb_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = SRAM_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_restart,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_last
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    // Depth is a power of two, so the last index is all ones.
    assign o_last = &r_cnt;

endmodule

// File: rtl/ct_spsram_2048x128_arb.sv
// ---------------------------------------------------------------------------
// ct_spsram_2048x128_arb
//  Shares one ct_spsram_2048x128 macro between a read and a write requester.
//  Zero-fills the array after reset or on init_req, then arbitrates
//  round-robin between the two requesters and drives the macro strobes.
//  Ports:
//   forever_cpuclk   in   clock (also the SRAM clock)
//   cpurst_b         in   asynchronous active-low reset
//   init_req         in   restart the zero-fill
//   init_done        out  fill complete, requests may be granted
//   rd_vld/rd_addr   in   read request
//   rd_rdy           out  read granted this cycle
//   rd_data_vld      out  read data valid (one cycle after the grant)
//   rd_data          out  read data (sram_q)
//   wr_vld/wr_addr/wr_data/wr_be  in  write request, wr_be active-high bit mask
//   wr_rdy           out  write granted this cycle
//   sram_cen/gwen/wen/a/d  out  macro strobes (active low), combinational
//   sram_q           in   macro read data
// ---------------------------------------------------------------------------
module ct_spsram_2048x128_arb
    import ct_spsram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rdy,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_vld,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_be,
    output logic                  wr_rdy,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic                    r_last_wr;
    logic                    r_rd_data_vld;
    logic [ADDR_WIDTH-1:0]   r_a_hold;
    logic [DATA_WIDTH-1:0]   r_d_hold;

    logic [ADDR_WIDTH-1:0]   w_cnt;
    logic                    w_cnt_last;
    logic                    w_run;
    logic                    w_init_acc;
    logic                    w_rd_gnt;
    logic                    w_wr_gnt;

    ct_spsram_init_cnt #(
        .CNT_WIDTH (ADDR_WIDTH)
    ) u_init_cnt (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .i_en      (r_state == INIT),
        .i_restart (init_req),
        .o_cnt     (w_cnt),
        .o_last    (w_cnt_last)
    );

    assign w_run = (r_state == RUN);

    // Reset gates the fill access so the strobes sit at their idle levels
    // while cpurst_b is low, even though the state register already reads INIT.
    assign w_init_acc = cpurst_b & (r_state == INIT);

    // Grants look only at the valids, the state and the round-robin flag.
    assign w_rd_gnt = w_run & rd_vld & (~wr_vld |  r_last_wr);
    assign w_wr_gnt = w_run & wr_vld & (~rd_vld | ~r_last_wr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (!init_req && w_cnt_last) w_state_nxt = RUN;
            RUN:     if (init_req)                w_state_nxt = INIT;
            default: w_state_nxt = INIT;
        endcase
    end

    // Macro strobes. a/d fall back to the registered copy of their last value
    // when the macro is idle so the wide buses do not toggle needlessly.
    always_comb begin
        sram_cen  = CEN_OFF;
        sram_gwen = GWEN_OFF;
        sram_wen  = WEN_OFF;
        sram_a    = r_a_hold;
        sram_d    = r_d_hold;
        if (w_init_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = w_cnt;
            sram_d    = '0;
        end else if (w_rd_gnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
        end else if (w_wr_gnt && (wr_be != '0)) begin
            // An all-zero mask is acknowledged but never touches the array.
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_be;
            sram_a    = wr_addr;
            sram_d    = wr_data;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state       <= INIT;
            r_last_wr     <= 1'b1;
            r_rd_data_vld <= 1'b0;
            r_a_hold      <= '0;
            r_d_hold      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            if (w_rd_gnt || w_wr_gnt) begin
                r_last_wr <= w_wr_gnt;
            end
            r_rd_data_vld <= w_rd_gnt;
            r_a_hold      <= sram_a;
            r_d_hold      <= sram_d;
        end
    end

    assign init_done   = w_run;
    assign rd_rdy      = w_rd_gnt;
    assign wr_rdy      = w_wr_gnt;
    assign rd_data_vld = r_rd_data_vld;
    assign rd_data     = sram_q;

endmodule

// File: tb/tb_ct_spsram_2048x128_arb.sv
module tb_ct_spsram_2048x128_arb;

    localparam int AW         = 11;
    localparam int DW         = 128;
    localparam int DEPTH      = 2048;
    localparam int FILL_BOUND = 3000;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          init_req;
    logic          init_done;
    logic          rd_vld;
    logic [AW-1:0] rd_addr;
    logic          rd_rdy;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_be;
    logic          wr_rdy;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ct_spsram_2048x128_arb dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .init_req       (init_req),
        .init_done      (init_done),
        .rd_vld         (rd_vld),
        .rd_addr        (rd_addr),
        .rd_rdy         (rd_rdy),
        .rd_data_vld    (rd_data_vld),
        .rd_data        (rd_data),
        .wr_vld         (wr_vld),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_be          (wr_be),
        .wr_rdy         (wr_rdy),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural 2048x128 macro: active-low strobes, 1-cycle Q latency.
    logic [DW-1:0] sram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = rand_word();
        sram_q = rand_word();
        forever begin
            @(posedge clk);
            if (!sram_cen) begin
                if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
                else            sram_q <= sram_mem[sram_a];
            end
        end
    end

    // Reference model: array contents, fill progress, who was served last,
    // and the read result owed on the next cycle.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_run;
    int            m_fill;
    bit            m_last_wr;
    bit            m_pend;
    logic [DW-1:0] m_pend_data;

    logic          o_rrdy, o_wrdy, o_dvld, o_done, o_cen;
    logic [DW-1:0] o_data;
    logic          e_rrdy, e_wrdy, e_dvld, e_done, e_cen;
    logic [DW-1:0] e_data;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_fill    = 0;
        m_last_wr = 1'b1;
        m_pend    = 1'b0;
        m_pend_data = '0;
        model_clear();
    endtask

    // One clock cycle: drive requests in the low phase, sample the outputs,
    // predict them from the model, advance the model, move to the next negedge.
    task automatic step(input bit rv, input logic [AW-1:0] ra, input bit wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wbe, input bit ireq);
        rd_vld = rv; rd_addr = ra; wr_vld = wv; wr_addr = wa;
        wr_data = wd; wr_be = wbe; init_req = ireq;
        #1;
        o_rrdy = rd_rdy; o_wrdy = wr_rdy; o_dvld = rd_data_vld;
        o_data = rd_data; o_done = init_done; o_cen = sram_cen;
        e_done = m_run;
        e_dvld = m_pend;
        e_data = m_pend_data;
        e_rrdy = m_run && rv && (!wv || m_last_wr);
        e_wrdy = m_run && wv && (!rv || !m_last_wr);
        e_cen  = !(!m_run || e_rrdy || (e_wrdy && (wbe != '0)));
        m_pend = e_rrdy;
        if (e_rrdy) m_pend_data = m_mem[ra];
        if (e_wrdy) m_mem[wa] = (m_mem[wa] & ~wbe) | (wd & wbe);
        if (e_rrdy || e_wrdy) m_last_wr = e_wrdy;
        if (ireq) begin
            m_run  = 1'b0;
            m_fill = 0;
            model_clear();
        end else if (!m_run) begin
            m_fill++;
            if (m_fill == DEPTH) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [DW-1:0] ones;
        ones = '1;
        rst_b = 1'b0; init_req = 1'b0;
        rd_vld = 1'b1; rd_addr = 11'd3; wr_vld = 1'b1; wr_addr = 11'd4;
        wr_data = rand_word(); wr_be = '1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (init_done !== 1'b0)   begin errors++; $display("FAIL reset init_done: got %b want 0", init_done); end
        checks++; if (rd_rdy !== 1'b0)      begin errors++; $display("FAIL reset rd_rdy: got %b want 0", rd_rdy); end
        checks++; if (wr_rdy !== 1'b0)      begin errors++; $display("FAIL reset wr_rdy: got %b want 0", wr_rdy); end
        checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL reset rd_data_vld: got %b want 0", rd_data_vld); end
        checks++; if (sram_cen !== 1'b1)    begin errors++; $display("FAIL reset sram_cen: got %b want 1", sram_cen); end
        checks++; if (sram_gwen !== 1'b1)   begin errors++; $display("FAIL reset sram_gwen: got %b want 1", sram_gwen); end
        checks++; if (sram_wen !== ones)    begin errors++; $display("FAIL reset sram_wen: got %h want all-1", sram_wen); end
        checks++; if (sram_a !== '0)        begin errors++; $display("FAIL reset sram_a: got %h want 0", sram_a); end
        checks++; if (sram_d !== '0)        begin errors++; $display("FAIL reset sram_d: got %h want 0", sram_d); end
    endtask

    // Runs a zero-fill from its first cycle to init_done; with busy set both
    // requesters stay valid the whole time. The fill must take DEPTH cycles.
    task automatic test_fill(input string tag, input bit busy);
        int cyc;
        bit seen;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < FILL_BOUND) begin
            step(busy && !m_run, AW'($urandom_range(0, DEPTH - 1)), busy && !m_run,
                 AW'($urandom_range(0, DEPTH - 1)), rand_word(), '1, 1'b0);
            checks++;
            if (o_rrdy !== e_rrdy || o_wrdy !== e_wrdy || o_done !== e_done || o_cen !== e_cen ||
                o_dvld !== e_dvld || (e_dvld && o_data !== e_data)) begin
                errors++;
                $display("FAIL %s cycle %0d: got rrdy=%b wrdy=%b done=%b cen=%b dvld=%b data=%h want %b %b %b %b %b %h",
                         tag, cyc, o_rrdy, o_wrdy, o_done, o_cen, o_dvld, o_data,
                         e_rrdy, e_wrdy, e_done, e_cen, e_dvld, e_data);
            end
            if (o_done === 1'b1) seen = 1'b1;
            else                 cyc++;
        end
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL %s length: got %0d cycles want %0d", tag, cyc, DEPTH);
        end
    endtask

    task automatic test_readback_all();
        for (int i = 0; i <= DEPTH; i++) begin
            step(i < DEPTH, AW'(i), 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if (o_dvld !== e_dvld || (e_dvld && o_data !== e_data)) begin
                errors++;
                $display("FAIL readback idx %0d: got dvld=%b data=%h want %b %h",
                         i - 1, o_dvld, o_data, e_dvld, e_data);
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        step(1'b0, '0, 1'b1, 11'h005, a5, '1, 1'b0);
        checks++; if (o_wrdy !== 1'b1 || o_rrdy !== 1'b0 || o_cen !== 1'b0) begin
            errors++; $display("FAIL wr grant: got wrdy=%b rrdy=%b cen=%b want 1 0 0", o_wrdy, o_rrdy, o_cen); end
        step(1'b1, 11'h005, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_rrdy !== 1'b1 || o_dvld !== 1'b0) begin
            errors++; $display("FAIL rd grant: got rrdy=%b dvld=%b want 1 0", o_rrdy, o_dvld); end
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_dvld !== 1'b1 || o_data !== a5) begin
            errors++; $display("FAIL rd after wr: got dvld=%b data=%h want 1 %h", o_dvld, o_data, a5); end
    endtask

    task automatic test_partial_write();
        logic [DW-1:0] want;
        want = {{8{8'hA5}}, 64'hFFFF_FFFF_FFFF_FFFF};
        step(1'b0, '0, 1'b1, 11'h005, '1, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0);
        checks++; if (o_wrdy !== 1'b1) begin
            errors++; $display("FAIL partial wr grant: got %b want 1", o_wrdy); end
        step(1'b1, 11'h005, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_dvld !== 1'b1 || o_data !== want) begin
            errors++; $display("FAIL partial wr data: got dvld=%b data=%h want 1 %h", o_dvld, o_data, want); end
    endtask

    task automatic test_wr_be_zero();
        logic [DW-1:0] want;
        want = {{8{8'hA5}}, 64'hFFFF_FFFF_FFFF_FFFF};
        step(1'b0, '0, 1'b1, 11'h005, rand_word(), '0, 1'b0);
        checks++; if (o_wrdy !== 1'b1 || o_cen !== 1'b1) begin
            errors++; $display("FAIL be0 write: got wrdy=%b cen=%b want 1 1", o_wrdy, o_cen); end
        step(1'b1, 11'h005, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_data !== want) begin
            errors++; $display("FAIL be0 data kept: got %h want %h", o_data, want); end
    endtask

    task automatic test_conflict();
        // A lone write first, so the read side is owed the next conflict.
        step(1'b0, '0, 1'b1, 11'h009, rand_word(), '1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, AW'($urandom_range(0, 15)), 1'b1, AW'($urandom_range(0, 15)),
                 rand_word(), '1, 1'b0);
            checks++;
            if (o_rrdy !== 1'((i % 2) == 0) || o_wrdy !== 1'((i % 2) == 1) || o_cen !== 1'b0 ||
                o_dvld !== e_dvld || (e_dvld && o_data !== e_data)) begin
                errors++;
                $display("FAIL conflict %0d: got rrdy=%b wrdy=%b cen=%b dvld=%b want rrdy=%b wrdy=%b cen=0 dvld=%b",
                         i, o_rrdy, o_wrdy, o_cen, o_dvld, 1'((i % 2) == 0), 1'((i % 2) == 1), e_dvld);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] be;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       be = '0;
                1:       be = '1;
                default: be = rand_word();
            endcase
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)), rand_word(), be, 1'b0);
            checks++;
            if (o_rrdy !== e_rrdy || o_wrdy !== e_wrdy || o_cen !== e_cen || o_dvld !== e_dvld ||
                (e_dvld && o_data !== e_data)) begin
                errors++;
                $display("FAIL random %0d: got rrdy=%b wrdy=%b cen=%b dvld=%b data=%h want %b %b %b %b %h",
                         i, o_rrdy, o_wrdy, o_cen, o_dvld, o_data, e_rrdy, e_wrdy, e_cen, e_dvld, e_data);
            end
        end
    endtask

    task automatic test_init_req();
        step(1'b0, '0, 1'b1, 11'h005, {16{8'hA5}}, '1, 1'b0);
        step(1'b1, 11'h005, 1'b1, 11'h006, rand_word(), '1, 1'b1);
        checks++;
        if (o_rrdy !== e_rrdy || o_wrdy !== e_wrdy || (o_rrdy ^ o_wrdy) !== 1'b1) begin
            errors++;
            $display("FAIL init_req grant: got rrdy=%b wrdy=%b want %b %b", o_rrdy, o_wrdy, e_rrdy, e_wrdy);
        end
        test_fill("init_req fill", 1'b1);
        step(1'b1, 11'h005, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_dvld !== 1'b1 || o_data !== '0) begin
            errors++; $display("FAIL 0x005 after init: got dvld=%b data=%h want 1 0", o_dvld, o_data); end
    endtask

    task automatic test_init_restart();
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 700; i++) step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        checks++; if (o_done !== 1'b0 || o_cen !== 1'b0) begin
            errors++; $display("FAIL restart mid-fill: got done=%b cen=%b want 0 0", o_done, o_cen); end
        test_fill("restarted fill", 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ones;
        ones = '1;
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 1000; i++) step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        rd_vld = 1'b1; wr_vld = 1'b1;
        #1;
        checks++; if (sram_a !== 11'd1000 || sram_cen !== 1'b0) begin
            errors++; $display("FAIL fill index: got a=%0d cen=%b want 1000 0", sram_a, sram_cen); end
        rst_b = 1'b0;
        #1;
        checks++;
        if (init_done !== 1'b0 || sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== ones ||
            sram_a !== '0 || sram_d !== '0 || rd_rdy !== 1'b0 || wr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset mid-fill: got done=%b cen=%b gwen=%b a=%h rrdy=%b wrdy=%b want 0 1 1 0 0 0",
                     init_done, sram_cen, sram_gwen, sram_a, rd_rdy, wr_rdy);
        end
        repeat (2) @(negedge clk);
        release_reset();
        test_fill("fill after mid-fill reset", 1'b0);

        step(1'b0, '0, 1'b1, 11'h007, rand_word(), '1, 1'b0);
        rd_vld = 1'b1; rd_addr = 11'h007; wr_vld = 1'b0;
        #1;
        checks++; if (rd_rdy !== 1'b1) begin
            errors++; $display("FAIL pre-reset read grant: got %b want 1", rd_rdy); end
        #1;
        rst_b = 1'b0;
        #1;
        checks++; if (sram_cen !== 1'b1 || rd_rdy !== 1'b0 || sram_a !== '0) begin
            errors++; $display("FAIL reset mid-read strobes: got cen=%b rrdy=%b a=%h want 1 0 0", sram_cen, rd_rdy, sram_a); end
        @(posedge clk);
        #1;
        checks++; if (rd_data_vld !== 1'b0) begin
            errors++; $display("FAIL reset mid-read dvld: got %b want 0", rd_data_vld); end
        rd_vld = 1'b0;
        release_reset();
        test_fill("fill after mid-read reset", 1'b0);
        step(1'b1, 11'h007, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (o_dvld !== 1'b1 || o_data !== '0) begin
            errors++; $display("FAIL 0x007 after reset fill: got dvld=%b data=%h want 1 0", o_dvld, o_data); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        release_reset();
        test_fill("first fill", 1'b0);
        test_readback_all();
        test_write_read();
        test_partial_write();
        test_wr_be_zero();
        test_conflict();
        test_random();
        test_init_req();
        test_init_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
